// File: rtl/rob_mc_pkg.sv
// Shared definitions for the reorder buffer: register-address width and
// branch-resolve decoding.
package rob_mc_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    BR_NONE   = 2'd0,
    BR_CLEAR  = 2'd1,
    BR_SQUASH = 2'd2
  } br_op_e;

  // Collapse the raw resolve strobes into one of three actions.
  function automatic br_op_e br_decode(input logic en, input logic miss);
    if (!en) return BR_NONE;
    return miss ? BR_SQUASH : BR_CLEAR;
  endfunction

endpackage

// File: rtl/rob_squash_scan.sv
// Finds the oldest squashed entry, scanning from head in program order with
// wrap-around. That index becomes the new tail after a mispredict.
module rob_squash_scan #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] squash,
  input  logic [TAG_W-1:0] head,
  output logic             any,
  output logic [TAG_W-1:0] tail_new
);

  logic [TAG_W-1:0] idx;

  // Walk from the youngest offset down so the oldest hit is written last.
  always_comb begin
    any      = |squash;
    tail_new = head;
    idx      = '0;
    for (int off = DEPTH - 1; off >= 0; off--) begin
      idx = head + TAG_W'(off);
      if (squash[idx]) tail_new = idx;
    end
  end

endmodule

// File: rtl/rob_mc.sv
// Multi-commit reorder buffer with branch-mask speculation.
// Optional feature macro ROB_WB_BYPASS_EN: when defined, same-cycle
// writebacks are forwarded to the operand read ports.
module rob_mc
  import rob_mc_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 32,
  parameter int BTAG_W   = 4,
  parameter int WB_PORTS = 2,
  parameter int COMMIT_W = 2,
  localparam int TAG_W   = $clog2(DEPTH),
  localparam int BIDX_W  = (BTAG_W > 1) ? $clog2(BTAG_W) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rdy,
  input  logic                             disp_en,
  input  logic [REG_ADDR_W-1:0]            disp_dest,
  input  logic [BTAG_W-1:0]                disp_bmask,
  output logic                             alloc_ready,
  output logic [TAG_W-1:0]                 alloc_tag,
  input  logic [WB_PORTS-1:0]              wb_en,
  input  logic [WB_PORTS*TAG_W-1:0]        wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]       wb_data,
  input  logic [2*TAG_W-1:0]               rd_tag,
  output logic [1:0]                       rd_hit,
  output logic [2*DATA_W-1:0]              rd_data,
  input  logic                             br_en,
  input  logic [BIDX_W-1:0]                br_idx,
  input  logic                             br_miss,
  output logic [COMMIT_W-1:0]              cm_valid,
  output logic [COMMIT_W*REG_ADDR_W-1:0]   cm_dest,
  output logic [COMMIT_W*DATA_W-1:0]       cm_data,
  output logic [TAG_W:0]                   occupancy
);

  logic [DEPTH-1:0]                       valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]       dest_q, dest_d;
  logic [DEPTH-1:0][DATA_W-1:0]           data_q, data_d;
  logic [DEPTH-1:0][BTAG_W-1:0]           bmask_q, bmask_d, eff_mask;
  logic [TAG_W-1:0]                       head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]                         count_q, count_d, n_cm;
  logic [COMMIT_W-1:0]                    cm_valid_q, cm_valid_d, lane_ok;
  logic [COMMIT_W-1:0][REG_ADDR_W-1:0]    cm_dest_q, cm_dest_d;
  logic [COMMIT_W-1:0][DATA_W-1:0]        cm_data_q, cm_data_d;
  logic [COMMIT_W-1:0][TAG_W-1:0]         lane_idx;
  logic [WB_PORTS-1:0][TAG_W-1:0]         wb_tag_a;
  logic [WB_PORTS-1:0][DATA_W-1:0]        wb_data_a;
  logic [1:0][TAG_W-1:0]                  rd_tag_a;
  logic [1:0][DATA_W-1:0]                 rd_data_a;
  logic [BTAG_W-1:0]                      clr_vec;
  logic [DEPTH-1:0]                       squash;
  logic [TAG_W-1:0]                       sq_tail;
  logic                                   sq_any, do_disp, run;
  br_op_e                                 br_op;

  assign wb_tag_a  = wb_tag;
  assign wb_data_a = wb_data;
  assign rd_tag_a  = rd_tag;
  assign rd_data   = rd_data_a;
  assign cm_valid  = cm_valid_q;
  assign cm_dest   = cm_dest_q;
  assign cm_data   = cm_data_q;
  assign occupancy = count_q;
  assign alloc_tag = tail_q;

  assign br_op       = br_decode(br_en, br_miss);
  assign clr_vec     = (br_op == BR_CLEAR) ? (BTAG_W'(1) << br_idx) : '0;
  // A just-freed slot is not reusable this cycle: fullness uses the registered count.
  assign alloc_ready = (count_q != (TAG_W+1)'(DEPTH)) && (br_op != BR_SQUASH);
  assign do_disp     = rdy & disp_en & alloc_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign eff_mask[i] = bmask_q[i] & ~clr_vec;
    assign squash[i]   = (br_op == BR_SQUASH) & valid_q[i] & bmask_q[i][br_idx];
  end

  rob_squash_scan #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_scan (
    .squash   (squash),
    .head     (head_q),
    .any      (sq_any),
    .tail_new (sq_tail)
  );

  // Operand lookup; with bypass a same-cycle writeback overrides stored state.
  always_comb begin
    rd_hit    = '0;
    rd_data_a = '0;
    for (int r = 0; r < 2; r++) begin
      rd_hit[r]    = valid_q[rd_tag_a[r]] & done_q[rd_tag_a[r]];
      rd_data_a[r] = data_q[rd_tag_a[r]];
`ifdef ROB_WB_BYPASS_EN
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_en[p] && (wb_tag_a[p] == rd_tag_a[r])) begin
          rd_hit[r]    = 1'b1;
          rd_data_a[r] = wb_data_a[p];
        end
      end
`endif
    end
  end

  // In-order commit lanes: a lane retires only if every older lane does.
  always_comb begin
    lane_ok  = '0;
    lane_idx = '0;
    n_cm     = '0;
    run      = 1'b1;
    for (int k = 0; k < COMMIT_W; k++) begin
      lane_idx[k] = head_q + TAG_W'(k);
      run         = run & valid_q[lane_idx[k]] & done_q[lane_idx[k]] & ~|eff_mask[lane_idx[k]];
      lane_ok[k]  = run;
      n_cm        = n_cm + (TAG_W+1)'(run);
    end
  end

  // Next state: writeback, commit, resolve/squash, dispatch; all held while stalled.
  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    dest_d     = dest_q;
    data_d     = data_q;
    bmask_d    = bmask_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    cm_valid_d = cm_valid_q;
    cm_dest_d  = cm_dest_q;
    cm_data_d  = cm_data_q;
    if (rdy) begin
      // Highest port first so the lowest index is applied last and wins.
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
        if (wb_en[p] && valid_q[wb_tag_a[p]]) begin
          done_d[wb_tag_a[p]] = 1'b1;
          data_d[wb_tag_a[p]] = wb_data_a[p];
        end
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        cm_valid_d[k] = lane_ok[k];
        cm_dest_d[k]  = lane_ok[k] ? dest_q[lane_idx[k]] : '0;
        cm_data_d[k]  = lane_ok[k] ? data_q[lane_idx[k]] : '0;
        if (lane_ok[k]) begin
          valid_d[lane_idx[k]] = 1'b0;
          done_d[lane_idx[k]]  = 1'b0;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        bmask_d[i] = eff_mask[i];
        if (squash[i]) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      head_d = head_q + n_cm[TAG_W-1:0];
      if (do_disp) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        dest_d[tail_q]  = disp_dest;
        bmask_d[tail_q] = disp_bmask & ~clr_vec;
        tail_d          = tail_q + 1'b1;
      end
      if (sq_any) begin
        tail_d  = sq_tail;
        count_d = {1'b0, sq_tail - head_d};
      end else begin
        count_d = count_q + (TAG_W+1)'(do_disp) - n_cm;
      end
    end
  end

  // State registers; reset discards every entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      done_q     <= '0;
      dest_q     <= '0;
      data_q     <= '0;
      bmask_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cm_valid_q <= '0;
      cm_dest_q  <= '0;
      cm_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      bmask_q    <= bmask_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cm_valid_q <= cm_valid_d;
      cm_dest_q  <= cm_dest_d;
      cm_data_q  <= cm_data_d;
    end
  end

endmodule

// File: tb/tb_rob_mc.sv
// Scoreboard bench for rob_mc: a program-order queue model predicts combinational
// outputs and per-cycle commit groups; a monitor compares registered commits.
`timescale 1ns/1ps
module tb_rob_mc;
  localparam int DEPTH = 16;
  localparam int CW    = 2;
  localparam int WBP   = 2;

  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b0, disp_en = 1'b0;
  logic [4:0]  disp_dest = '0;
  logic [3:0]  disp_bmask = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic [1:0]  wb_en = '0;
  logic [7:0]  wb_tag = '0;
  logic [63:0] wb_data = '0;
  logic [7:0]  rd_tag = '0;
  logic [1:0]  rd_hit;
  logic [63:0] rd_data;
  logic        br_en = 1'b0, br_miss = 1'b0;
  logic [1:0]  br_idx = '0;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_dest;
  logic [63:0] cm_data;
  logic [4:0]  occupancy;

  rob_mc dut (
    .clk(clk), .rst(rst), .rdy(rdy), .disp_en(disp_en), .disp_dest(disp_dest),
    .disp_bmask(disp_bmask), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .rd_tag(rd_tag),
    .rd_hit(rd_hit), .rd_data(rd_data), .br_en(br_en), .br_idx(br_idx),
    .br_miss(br_miss), .cm_valid(cm_valid), .cm_dest(cm_dest), .cm_data(cm_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    logic [31:0] data;
    bit          done;
    logic [3:0]  mask;
  } ent_t;

  typedef struct {
    int              n;
    logic [1:0][4:0]  dest;
    logic [1:0][31:0] data;
  } cm_t;

  ent_t       mq[$];      // live entries, oldest first
  cm_t        expq[$];    // expected commit group per active edge
  int         mtail = 0;
  logic [3:0] live_br = '0;
  int         br_order[$];
  int         errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    expq.delete();
    br_order.delete();
    mtail   = 0;
    live_br = '0;
  endtask

  task automatic idle();
    rdy = 1'b1; disp_en = 1'b0; disp_bmask = '0; wb_en = '0;
    br_en = 1'b0; br_miss = 1'b0; rd_tag = '0;
  endtask

  task automatic check_comb();
    int sz;
    sz = mq.size();
    chk("alloc_ready", {63'd0, alloc_ready}, {63'd0, (sz < DEPTH) && !(br_en && br_miss)});
    chk("alloc_tag", {60'd0, alloc_tag}, 64'(mtail));
    chk("occupancy", {59'd0, occupancy}, 64'(sz));
    for (int r = 0; r < 2; r++) begin
      int t;
      bit h;
      logic [31:0] d;
      t = int'(rd_tag[r*4 +: 4]);
      h = 1'b0;
      d = '0;
      foreach (mq[i]) if (mq[i].tag == t && mq[i].done) begin h = 1'b1; d = mq[i].data; end
`ifdef ROB_WB_BYPASS_EN
      for (int p = WBP - 1; p >= 0; p--)
        if (wb_en[p] && int'(wb_tag[p*4 +: 4]) == t) begin h = 1'b1; d = wb_data[p*32 +: 32]; end
`endif
      chk($sformatf("rd_hit%0d", r), {63'd0, rd_hit[r]}, {63'd0, h});
      if (h) chk($sformatf("rd_data%0d", r), {32'd0, rd_data[r*32 +: 32]}, {32'd0, d});
    end
  endtask

  // One cycle of the behavioural ROB: commit, writeback, resolve, dispatch.
  task automatic model_step(output bit disp_ok);
    bit   miss, clr, stop;
    int   sz0, n;
    cm_t  e;
    logic [3:0] m;
    disp_ok = 1'b0;
    if (!rdy) return;
    miss = br_en && br_miss;
    clr  = br_en && !br_miss;
    sz0  = mq.size();
    n    = 0;
    stop = 1'b0;
    while (!stop && n < CW && n < mq.size()) begin
      m = mq[n].mask;
      if (clr) m[br_idx] = 1'b0;
      if (mq[n].done && m == 4'd0) n++;
      else stop = 1'b1;
    end
    e.n = n; e.dest = '0; e.data = '0;
    for (int k = 0; k < n; k++) begin
      e.dest[k] = mq[0].dest;
      e.data[k] = mq[0].data;
      void'(mq.pop_front());
    end
    expq.push_back(e);
    for (int p = WBP - 1; p >= 0; p--)
      if (wb_en[p])
        foreach (mq[i])
          if (mq[i].tag == int'(wb_tag[p*4 +: 4])) begin
            mq[i].done = 1'b1;
            mq[i].data = wb_data[p*32 +: 32];
          end
    if (miss) begin
      ent_t keep[$];
      bit first;
      first = 1'b1;
      foreach (mq[i]) begin
        if (mq[i].mask[br_idx]) begin
          if (first) begin mtail = mq[i].tag; first = 1'b0; end
        end else keep.push_back(mq[i]);
      end
      mq = keep;
    end
    if (clr) foreach (mq[i]) mq[i].mask[br_idx] = 1'b0;
    if (disp_en && sz0 < DEPTH && !miss) begin
      ent_t ne;
      ne.tag = mtail; ne.dest = disp_dest; ne.data = '0; ne.done = 1'b0; ne.mask = disp_bmask;
      if (clr) ne.mask[br_idx] = 1'b0;
      mq.push_back(ne);
      mtail   = (mtail + 1) % DEPTH;
      disp_ok = 1'b1;
    end
  endtask

  // Inputs are set at a falling edge; check and advance model, then wait a cycle.
  task automatic tick(output bit dok);
    #1;
    check_comb();
    model_step(dok);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("rst_occupancy", {59'd0, occupancy}, 64'd0);
    chk("rst_alloc_ready", {63'd0, alloc_ready}, 64'd1);
    chk("rst_cm_valid", {62'd0, cm_valid}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wb1(input int port, input int tag, input logic [31:0] d);
    wb_en[port] = 1'b1;
    wb_tag[port*4 +: 4] = 4'(tag);
    wb_data[port*32 +: 32] = d;
  endtask

  // Commit monitor: one expected group per edge where the ROB was not stalled.
  always @(posedge clk) begin
    logic r;
    cm_t  ce;
    r = rdy & ~rst;
    #1;
    if (r) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL cm_underflow: commit edge with no expected group");
      end else begin
        ce = expq.pop_front();
        for (int k = 0; k < CW; k++) begin
          chk($sformatf("cm_valid%0d", k), {63'd0, cm_valid[k]}, {63'd0, k < ce.n});
          if (k < ce.n) begin
            chk($sformatf("cm_dest%0d", k), {59'd0, cm_dest[k*5 +: 5]}, {59'd0, ce.dest[k]});
            chk($sformatf("cm_data%0d", k), {32'd0, cm_data[k*32 +: 32]}, {32'd0, ce.data[k]});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit dok;
    int bi, fb;
    @(negedge clk);
    do_reset();

    // Fill: 17th dispatch is refused, occupancy 16, tail wrapped to 0.
    for (int i = 0; i < 17; i++) begin
      idle(); disp_en = 1'b1; disp_dest = 5'(i); tick(dok);
    end
    do_reset();

    // Two writebacks via both ports commit together, then t2 alone, t3 stays.
    for (int i = 0; i < 4; i++) begin idle(); disp_en = 1'b1; disp_dest = 5'(i + 1); tick(dok); end
    idle(); wb1(0, 1, 32'h1111); wb1(1, 0, 32'h1010); tick(dok);
    idle(); tick(dok);
    idle(); wb1(0, 2, 32'h2222); wb1(1, 2, 32'h9999); tick(dok);
    for (int i = 0; i < 3; i++) begin idle(); tick(dok); end
    do_reset();

    // Mispredict squashes t1..t3 and drops the same-cycle dispatch.
    idle(); disp_en = 1'b1; disp_dest = 5'd7; tick(dok);
    for (int i = 0; i < 3; i++) begin
      idle(); disp_en = 1'b1; disp_dest = 5'(8 + i); disp_bmask = 4'b0001; wb1(0, i, 32'(i)); tick(dok);
    end
    idle(); br_en = 1'b1; br_miss = 1'b1; br_idx = 2'd0; disp_en = 1'b1; disp_dest = 5'd3; tick(dok);
    idle(); wb1(0, 0, 32'hA0A0); tick(dok);
    for (int i = 0; i < 3; i++) begin idle(); tick(dok); end
    do_reset();

    // Correct resolve lets a done speculative entry commit right after t0.
    idle(); disp_en = 1'b1; disp_dest = 5'd4; tick(dok);
    idle(); disp_en = 1'b1; disp_dest = 5'd5; disp_bmask = 4'b0001; tick(dok);
    idle(); wb1(0, 0, 32'hC0); wb1(1, 1, 32'hC1); tick(dok);
    idle(); br_en = 1'b1; br_idx = 2'd0; tick(dok);
    for (int i = 0; i < 3; i++) begin idle(); tick(dok); end
    do_reset();

    // Writeback forwarding on the read port.
    for (int i = 0; i < 6; i++) begin idle(); disp_en = 1'b1; disp_dest = 5'(i); disp_bmask = 4'b0100; tick(dok); end
    idle(); wb1(0, 5, 32'hDEAD); rd_tag = 8'h35; tick(dok);
    idle(); rd_tag = 8'h35; tick(dok);
    do_reset();

    // Wrap: head reaches 14, then squash of the last three wraps tail to 15.
    for (int i = 0; i < 14; i++) begin
      idle(); disp_en = 1'b1; disp_dest = 5'(i);
      if (i > 0) wb1(0, i - 1, 32'(i + 100));
      tick(dok);
    end
    idle(); wb1(0, 13, 32'd113); tick(dok);
    for (int i = 0; i < 4; i++) begin idle(); tick(dok); end
    idle(); disp_en = 1'b1; disp_dest = 5'd20; tick(dok);
    for (int i = 0; i < 3; i++) begin idle(); disp_en = 1'b1; disp_dest = 5'(21 + i); disp_bmask = 4'b0010; tick(dok); end
    idle(); br_en = 1'b1; br_miss = 1'b1; br_idx = 2'd1; tick(dok);
    for (int i = 0; i < 2; i++) begin idle(); tick(dok); end
    do_reset();

    // Randomised traffic with well-formed nested branch masks and stalls.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset();
      idle();
      rdy        = ($urandom_range(0, 9) != 0);
      disp_en    = ($urandom_range(0, 9) < 6);
      disp_dest  = 5'($urandom);
      disp_bmask = live_br;
      for (int p = 0; p < WBP; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          int t;
          if (mq.size() > 0 && $urandom_range(0, 7) != 0) t = mq[$urandom_range(0, mq.size() - 1)].tag;
          else t = int'($urandom_range(0, 15));
          wb1(p, t, $urandom);
        end
      end
      if ($urandom_range(0, 9) == 0) wb_tag[7:4] = wb_tag[3:0];
      rd_tag = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rd_tag[3:0] = wb_tag[3:0];
      bi = 0;
      if (br_order.size() > 0 && $urandom_range(0, 7) == 0) begin
        bi      = $urandom_range(0, br_order.size() - 1);
        br_en   = 1'b1;
        br_idx  = 2'(br_order[bi]);
        br_miss = ($urandom_range(0, 2) == 0);
      end
      tick(dok);
      if (rdy) begin
        if (br_en) begin
          if (br_miss) begin
            while (br_order.size() > bi) begin
              live_br[br_order[br_order.size() - 1]] = 1'b0;
              void'(br_order.pop_back());
            end
          end else begin
            live_br[br_idx] = 1'b0;
            br_order.delete(bi);
          end
        end
        if (dok && live_br != 4'hF && $urandom_range(0, 3) == 0) begin
          fb = 0;
          for (int b = 0; b < 4; b++) if (!live_br[b]) fb = b;
          live_br[fb] = 1'b1;
          br_order.push_back(fb);
        end
      end
    end
    idle(); tick(dok);
    chk("expq_drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
